// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped data cache.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      WDONE
   } state_e;

   function automatic int tag_w(input int index_bits);
      return 30 - index_bits;
   endfunction

   function automatic int line_cnt(input int index_bits);
      return 1 << index_bits;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: asynchronous lookup, one synchronous write port.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [31:2] addr_i,
   input  logic        we_i,
   input  logic [31:0] wdata_i,
   output logic        hit_o,
   output logic [31:0] rdata_o
);

   localparam int TW = tag_w(INDEX_BITS);
   localparam int NL = line_cnt(INDEX_BITS);

   logic [NL-1:0]         valid_q;
   logic [TW-1:0]         tag_q  [NL];
   logic [31:0]           data_q [NL];
   logic [INDEX_BITS-1:0] idx;
   logic [TW-1:0]         tag;

   assign idx     = addr_i[INDEX_BITS+1:2];
   assign tag     = addr_i[31:INDEX_BITS+2];
   assign hit_o   = valid_q[idx] && (tag_q[idx] == tag);
   assign rdata_o = data_q[idx];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[idx] <= 1'b1;
      end
   end

   // Tag/data need no reset: they are only observed behind a valid bit.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[idx]  <= tag;
         data_q[idx] <= wdata_i;
      end
   end

endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-through, no-write-allocate data cache with
// req/ack backing-memory port and saturating hit/miss counters.
module dcache_dm
   import dcache_pkg::*;
#(
   parameter int INDEX_BITS = 6,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             rd_i,
   input  logic             wr_i,
   input  logic [31:0]      addr_i,
   input  logic [31:0]      data_i,
   output logic [31:0]      data_o,
   output logic             valid_o,
   output logic             mem_req_o,
   output logic             mem_we_o,
   output logic [31:0]      mem_addr_o,
   output logic [31:0]      mem_wdata_o,
   input  logic [31:0]      mem_rdata_i,
   input  logic             mem_ack_i,
   output logic [CNT_W-1:0] hit_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   state_e           state_q, state_d;
   logic             refill_q, refill_d;
   logic [CNT_W-1:0] hit_q, hit_d;
   logic [CNT_W-1:0] miss_q, miss_d;
   logic             hit;
   logic [31:0]      rdata;
   logic             arr_we;
   logic [31:0]      arr_wdata;
   logic             is_wr, is_rd;
   logic [31:0]      word_addr;
   logic             unused_addr;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Requests are masked while in reset so the port reads as idle at once.
   assign is_wr       = rst_n_i & wr_i;
   assign is_rd       = rst_n_i & rd_i & ~wr_i;
   assign word_addr   = {addr_i[31:2], 2'b00};
   assign unused_addr = ^addr_i[1:0];
   assign hit_cnt_o   = hit_q;
   assign miss_cnt_o  = miss_q;

   dcache_array #(
      .INDEX_BITS(INDEX_BITS)
   ) u_array (
      .clk_i  (clk_i),
      .rst_n_i(rst_n_i),
      .addr_i (addr_i[31:2]),
      .we_i   (arr_we),
      .wdata_i(arr_wdata),
      .hit_o  (hit),
      .rdata_o(rdata)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         refill_q <= 1'b0;
         hit_q    <= '0;
         miss_q   <= '0;
      end else begin
         state_q  <= state_d;
         refill_q <= refill_d;
         hit_q    <= hit_d;
         miss_q   <= miss_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      refill_d    = 1'b0;
      hit_d       = hit_q;
      miss_d      = miss_q;
      valid_o     = 1'b0;
      data_o      = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      arr_we      = 1'b0;
      arr_wdata   = mem_rdata_i;
      unique case (state_q)
         IDLE: begin
            if (is_wr) begin
               state_d = WRITE;
            end else if (is_rd) begin
               if (hit) begin
                  valid_o = 1'b1;
                  data_o  = rdata;
                  // The lookup right after a fill is not a fresh hit.
                  if (!refill_q) hit_d = sat_inc(hit_q);
               end else begin
                  state_d = FILL;
                  miss_d  = sat_inc(miss_q);
               end
            end else begin
               valid_o = 1'b1;
            end
         end
         FILL: begin
            mem_req_o  = 1'b1;
            mem_addr_o = word_addr;
            if (mem_ack_i) begin
               arr_we   = 1'b1;
               refill_d = 1'b1;
               state_d  = IDLE;
            end
         end
         WRITE: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = word_addr;
            mem_wdata_o = data_i;
            if (mem_ack_i) begin
               arr_we    = hit;
               arr_wdata = data_i;
               state_d   = WDONE;
            end
         end
         WDONE: begin
            valid_o = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_dm.sv
// Randomized self-checking bench for dcache_dm against a behavioural cache model.
module tb_dcache_dm;

   localparam int IB = 6;
   localparam int CW = 16;
   localparam int NL = 1 << IB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          rd_i, wr_i;
   logic [31:0]   addr_i, data_i;
   logic [31:0]   data_o;
   logic          valid_o;
   logic          mem_req_o, mem_we_o;
   logic [31:0]   mem_addr_o, mem_wdata_o;
   logic [31:0]   mem_rdata_i;
   logic          mem_ack_i;
   logic [CW-1:0] hit_cnt_o, miss_cnt_o;

   always #5 clk = ~clk;

   dcache_dm #(
      .INDEX_BITS(IB),
      .CNT_W     (CW)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .rd_i       (rd_i),
      .wr_i       (wr_i),
      .addr_i     (addr_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .mem_req_o  (mem_req_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_wdata_o(mem_wdata_o),
      .mem_rdata_i(mem_rdata_i),
      .mem_ack_i  (mem_ack_i),
      .hit_cnt_o  (hit_cnt_o),
      .miss_cnt_o (miss_cnt_o)
   );

   int checks = 0;
   int errors = 0;

   // Backing memory seen by the responder, and the model's own copy.
   logic [31:0] mem  [logic [31:0]];
   logic [31:0] rmem [logic [31:0]];
   int ack_delay = 0;
   int wcnt = 0;

   // Model cache state
   bit          mv [NL];
   logic [23:0] mt [NL];
   logic [31:0] md [NL];
   int          exp_hit, exp_miss;

   function automatic logic [31:0] dflt(input logic [31:0] wa);
      return (wa * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int sat(input int v);
      return (v >= (1 << CW) - 1) ? v : v + 1;
   endfunction

   always @(negedge clk) begin
      if (mem_ack_i) begin
         mem_ack_i = 1'b0;
         wcnt = 0;
      end else if (mem_req_o) begin
         if (wcnt >= ack_delay) begin
            mem_ack_i = 1'b1;
            if (mem_we_o) mem[mem_addr_o] = mem_wdata_o;
            else mem_rdata_i = mem.exists(mem_addr_o) ? mem[mem_addr_o]
                                                      : dflt(mem_addr_o);
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   task automatic model_reset();
      for (int i = 0; i < NL; i++) mv[i] = 1'b0;
      exp_hit = 0;
      exp_miss = 0;
   endtask

   task automatic do_req(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int dly);
      int          idx;
      logic [23:0] tg;
      bit          hitm;
      int          exp_lat;
      logic [31:0] exp_data;
      logic [31:0] wa;
      int          cyc;
      bit          seen;
      logic [31:0] got;
      wa = {a[31:2], 2'b00};
      idx = int'(a[7:2]);
      tg = a[31:8];
      hitm = mv[idx] && (mt[idx] == tg);
      if (w) begin
         exp_lat = 2 + dly;
         exp_data = 32'h0;
      end else if (hitm) begin
         exp_lat = 0;
         exp_data = md[idx];
      end else begin
         exp_lat = 2 + dly;
         exp_data = rmem.exists(wa) ? rmem[wa] : dflt(wa);
      end
      ack_delay = dly;
      @(negedge clk);
      rd_i = r; wr_i = w; addr_i = a; data_i = d;
      #1;
      cyc = 0;
      seen = 0;
      while (!valid_o && cyc < 100) begin
         if (mem_req_o && !seen) begin
            seen = 1;
            checks++;
            if (mem_we_o !== w || mem_addr_o !== wa || (w && mem_wdata_o !== d)) begin
               errors++;
               $display("FAIL memreq a=%h: we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                        a, mem_we_o, mem_addr_o, mem_wdata_o, w, wa, d);
            end
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      got = data_o;
      checks++;
      if (cyc !== exp_lat) begin
         errors++;
         $display("FAIL latency a=%h r=%b w=%b: got %0d cycles, want %0d", a, r, w, cyc, exp_lat);
      end
      checks++;
      if (got !== exp_data) begin
         errors++;
         $display("FAIL data a=%h r=%b w=%b: got %h, want %h", a, r, w, got, exp_data);
      end
      checks++;
      if (seen !== (exp_lat != 0)) begin
         errors++;
         $display("FAIL memuse a=%h: mem_req seen=%b, want %b", a, seen, exp_lat != 0);
      end
      if (w) begin
         if (hitm) md[idx] = d;
         rmem[wa] = d;
      end else if (hitm) begin
         exp_hit = sat(exp_hit);
      end else begin
         exp_miss = sat(exp_miss);
         mv[idx] = 1'b1;
         mt[idx] = tg;
         md[idx] = exp_data;
      end
      @(posedge clk);
      #1;
      rd_i = 1'b0;
      wr_i = 1'b0;
      #1;
      checks++;
      if (hit_cnt_o !== CW'(exp_hit) || miss_cnt_o !== CW'(exp_miss)) begin
         errors++;
         $display("FAIL counters a=%h: hit=%0d miss=%0d, want hit=%0d miss=%0d",
                  a, hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
      end
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h0 || mem_req_o !== 1'b0) begin
         errors++;
         $display("FAIL idle a=%h: valid=%b data=%h req=%b, want 1 0 0",
                  a, valid_o, data_o, mem_req_o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rd_i = 0; wr_i = 0; addr_i = 0; data_i = 0;
      mem_ack_i = 0; mem_rdata_i = 0;
      model_reset();
      #1;
      checks++;
      if (valid_o !== 1'b1 || data_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_port: valid=%b data=%h, want 1 0", valid_o, data_o);
      end
      checks++;
      if (mem_req_o !== 0 || mem_we_o !== 0 || mem_addr_o !== 0 || mem_wdata_o !== 0) begin
         errors++;
         $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, want all 0",
                  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      checks++;
      if (hit_cnt_o !== 0 || miss_cnt_o !== 0) begin
         errors++;
         $display("FAIL reset_cnt: hit=%0d miss=%0d, want 0 0", hit_cnt_o, miss_cnt_o);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_cold_read();
      mem[32'h40] = 32'hDEAD_BEEF;
      rmem[32'h40] = 32'hDEAD_BEEF;
      do_req(1, 0, 32'h40, 0, 3);
   endtask

   task automatic test_repeat_hit();
      do_req(1, 0, 32'h40, 0, 0);
   endtask

   task automatic test_store_hit();
      do_req(0, 1, 32'h40, 32'h1234_5678, 1);
      do_req(1, 0, 32'h40, 0, 0);
   endtask

   task automatic test_store_miss();
      do_req(0, 1, 32'h1000, 32'hCAFE_F00D, 0);
      do_req(1, 0, 32'h1000, 0, 0);
   endtask

   task automatic test_conflict();
      do_req(1, 0, 32'h40, 0, 0);
      do_req(1, 0, 32'h140, 0, 2);
      do_req(1, 0, 32'h40, 0, 1);
      do_req(1, 1, 32'h80, 32'hA5A5_5A5A, 0);
   endtask

   task automatic test_random();
      int          op;
      logic [31:0] a;
      for (int i = 0; i < 300; i++) begin
         op = $urandom_range(0, 9);
         a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         if (op < 6) do_req(1, 0, a, $urandom, $urandom_range(0, 3));
         else if (op < 9) do_req(0, 1, a, $urandom, $urandom_range(0, 3));
         else do_req(1, 1, a, $urandom, $urandom_range(0, 3));
      end
   endtask

   task automatic test_reset_mid_fill();
      do_req(1, 0, 32'h40, 0, 0);
      ack_delay = 50;
      @(negedge clk);
      rd_i = 1'b1; addr_i = 32'h200;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (mem_req_o !== 1'b1) begin
         errors++;
         $display("FAIL fill_active: req=%b, want 1", mem_req_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (mem_req_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 32'h0) begin
         errors++;
         $display("FAIL reset_abort: req=%b valid=%b data=%h, want 0 1 0",
                  mem_req_o, valid_o, data_o);
      end
      checks++;
      if (hit_cnt_o !== 0 || miss_cnt_o !== 0) begin
         errors++;
         $display("FAIL reset_abort_cnt: hit=%0d miss=%0d, want 0 0", hit_cnt_o, miss_cnt_o);
      end
      rd_i = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      do_req(1, 0, 32'h40, 0, 0);
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_repeat_hit();
      test_store_hit();
      test_store_miss();
      test_conflict();
      test_random();
      test_reset_mid_fill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
